// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: turns one LDM/STM register list into a stream of
// single-register micro-ops (ascending register -> ascending address),
// then an optional base writeback and a one-cycle completion pulse.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       reglist,
  input  logic [4:0]        nregs,
  input  logic [ADDR_W-1:0] base,
  input  logic              pre,
  input  logic              up,
  input  logic              load,
  input  logic              wback,
  input  logic              flush,
  input  logic              uop_ready,
  output logic              busy,
  output logic              uop_valid,
  output logic [3:0]        uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_load,
  output logic              uop_last,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_value,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       mask;
  logic [4:0]        cnt;
  logic [ADDR_W-1:0] addr, wbv;
  logic              load_q, wback_q;
  logic [3:0]        low_idx;
  logic [ADDR_W-1:0] four_n, start_addr, wb_calc;
  logic              accept, advance;

  assign accept  = (state == IDLE) && start && !flush;
  assign advance = (state == XFER) && uop_ready && !flush;

  // Block size in bytes and the lowest-address word of the block. The
  // transfer always walks upward; decrement modes just start lower.
  always_comb begin
    four_n = ADDR_W'({nregs, 2'b00});
    unique case ({pre, up})
      2'b01:   start_addr = base;
      2'b11:   start_addr = base + ADDR_W'(4);
      2'b00:   start_addr = base - four_n + ADDR_W'(4);
      default: start_addr = base - four_n;
    endcase
    wb_calc = up ? (base + four_n) : (base - four_n);
  end

  // Lowest set bit of the remaining mask picks the next register.
  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--)
      if (mask[i]) low_idx = 4'(i);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; flush overrides everything and drops back to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (nregs != 5'd0) ? XFER : DONE;
      XFER:    if (uop_ready && cnt == 5'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Transfer context: latched on accept, stepped on each accepted micro-op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask    <= '0;
      cnt     <= '0;
      addr    <= '0;
      wbv     <= '0;
      load_q  <= 1'b0;
      wback_q <= 1'b0;
    end else if (accept) begin
      mask    <= reglist;
      cnt     <= nregs;
      addr    <= start_addr;
      wbv     <= wb_calc;
      load_q  <= load;
      // An empty list never writes back, even with W set.
      wback_q <= wback && (nregs != 5'd0);
    end else if (advance) begin
      mask <= mask & (mask - 16'd1);
      cnt  <= cnt - 5'd1;
      addr <= addr + ADDR_W'(4);
    end
  end

  // Outputs decode from registered state only (flush may suppress the
  // completion pulses in the cycle it arrives).
  always_comb begin
    busy      = (state != IDLE);
    uop_valid = (state == XFER);
    uop_reg   = low_idx;
    uop_addr  = addr;
    uop_load  = load_q;
    uop_last  = (state == XFER) && (cnt == 5'd1);
    done      = (state == DONE) && !flush;
    wb_valid  = (state == DONE) && wback_q && !flush;
    wb_value  = wbv;
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: inputs driven and outputs sampled
// on the falling edge, expected values computed by hand.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, pre, up, load, wback, flush, uop_ready;
  logic [15:0] reglist;
  logic [4:0]  nregs;
  logic [31:0] base;
  logic        busy, uop_valid, uop_load, uop_last, wb_valid, done;
  logic [3:0]  uop_reg;
  logic [31:0] uop_addr, wb_value;

  int checks = 0;
  int passed = 0;

  ldm_stm_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .reglist(reglist), .nregs(nregs),
    .base(base), .pre(pre), .up(up), .load(load), .wback(wback), .flush(flush),
    .uop_ready(uop_ready), .busy(busy), .uop_valid(uop_valid), .uop_reg(uop_reg),
    .uop_addr(uop_addr), .uop_load(uop_load), .uop_last(uop_last),
    .wb_valid(wb_valid), .wb_value(wb_value), .done(done)
  );

  always #5 clk = ~clk;

  // Decode must hand over a count that matches the list.
  always @(posedge clk)
    if (reset && start && !busy)
      assert (nregs == 5'($countones(reglist)));

  // Present one start for one cycle; returns at the negedge after acceptance.
  task automatic go(input logic [15:0] rl, input logic [31:0] b,
                    input logic p, input logic u, input logic l, input logic w);
    @(negedge clk);
    start = 1'b1; reglist = rl; nregs = 5'($countones(rl)); base = b;
    pre = p; up = u; load = l; wback = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; reglist = 0; nregs = 0; base = 0;
    pre = 0; up = 0; load = 0; wback = 0; flush = 0; uop_ready = 0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, uop_valid, uop_last, wb_valid, done, uop_load} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000", {busy, uop_valid, uop_last, wb_valid, done, uop_load});
    else passed++;
    checks++; if (uop_reg !== 4'd0 || uop_addr !== 32'd0 || wb_value !== 32'd0)
      $display("FAIL reset_data got reg=%0d addr=%h wb=%h want 0", uop_reg, uop_addr, wb_value);
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_ia_stm();
    logic [3:0]  er[3] = '{4'd0, 4'd2, 4'd15};
    logic [31:0] ea[3] = '{32'h1000, 32'h1004, 32'h1008};
    uop_ready = 1'b1;
    go(16'h8005, 32'h1000, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++; if (!(uop_valid === 1'b1 && busy === 1'b1 && uop_reg === er[k] && uop_addr === ea[k]
                      && uop_last === (k == 2) && uop_load === 1'b0))
        $display("FAIL ia_uop%0d got v=%b r=%0d a=%h last=%b ld=%b want v=1 r=%0d a=%h last=%b ld=0",
                 k, uop_valid, uop_reg, uop_addr, uop_last, uop_load, er[k], ea[k], (k == 2));
      else passed++;
      @(negedge clk);
    end
    checks++; if (!(done === 1'b1 && wb_valid === 1'b1 && wb_value === 32'h100C && uop_valid === 1'b0))
      $display("FAIL ia_done got done=%b wbv=%b wb=%h uv=%b want 1 1 0000100c 0", done, wb_valid, wb_value, uop_valid);
    else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL ia_idle got busy=%b done=%b want 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_db_ldm();
    logic [31:0] ea[4] = '{32'h1FF0, 32'h1FF4, 32'h1FF8, 32'h1FFC};
    uop_ready = 1'b1;
    go(16'h00F0, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (!(uop_valid === 1'b1 && uop_reg === 4'(4 + k) && uop_addr === ea[k]
                      && uop_last === (k == 3) && uop_load === 1'b1))
        $display("FAIL db_uop%0d got v=%b r=%0d a=%h last=%b ld=%b want v=1 r=%0d a=%h last=%b ld=1",
                 k, uop_valid, uop_reg, uop_addr, uop_last, uop_load, 4 + k, ea[k], (k == 3));
      else passed++;
      @(negedge clk);
    end
    checks++; if (!(done === 1'b1 && wb_valid === 1'b1 && wb_value === 32'h1FF0))
      $display("FAIL db_done got done=%b wbv=%b wb=%h want 1 1 00001ff0", done, wb_valid, wb_value);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] ea[4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};
    uop_ready = 1'b1;
    go(16'h000F, 32'hFFFFFFF8, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (!(uop_valid === 1'b1 && uop_reg === 4'(k) && uop_addr === ea[k]))
        $display("FAIL wrap_uop%0d got v=%b r=%0d a=%h want v=1 r=%0d a=%h",
                 k, uop_valid, uop_reg, uop_addr, k, ea[k]);
      else passed++;
      @(negedge clk);
    end
    checks++; if (!(done === 1'b1 && wb_valid === 1'b1 && wb_value === 32'h8))
      $display("FAIL wrap_done got done=%b wbv=%b wb=%h want 1 1 00000008", done, wb_valid, wb_value);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    uop_ready = 1'b0;
    go(16'h0003, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (!(uop_valid === 1'b1 && uop_reg === 4'd0 && uop_addr === 32'h104 && uop_last === 1'b0))
        $display("FAIL bp_hold%0d got v=%b r=%0d a=%h last=%b want v=1 r=0 a=00000104 last=0",
                 k, uop_valid, uop_reg, uop_addr, uop_last);
      else passed++;
      // Stray start while busy, with a different list, must be ignored.
      if (k == 1) begin start = 1'b1; reglist = 16'hFFFF; nregs = 5'd16; base = 32'h9000; end
      if (k == 2) start = 1'b0;
      if (k == 3) uop_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (!(uop_valid === 1'b1 && uop_reg === 4'd1 && uop_addr === 32'h108 && uop_last === 1'b1))
      $display("FAIL bp_second got v=%b r=%0d a=%h last=%b want v=1 r=1 a=00000108 last=1",
               uop_valid, uop_reg, uop_addr, uop_last);
    else passed++;
    @(negedge clk);
    checks++; if (!(done === 1'b1 && wb_valid === 1'b0 && wb_value === 32'h108))
      $display("FAIL bp_done got done=%b wbv=%b wb=%h want 1 0 00000108", done, wb_valid, wb_value);
    else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || uop_valid !== 1'b0)
      $display("FAIL bp_idle got busy=%b uv=%b want 0 0", busy, uop_valid);
    else passed++;
  endtask

  task automatic test_empty();
    uop_ready = 1'b1;
    go(16'h0000, 32'h500, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (!(done === 1'b1 && wb_valid === 1'b0 && uop_valid === 1'b0 && busy === 1'b1))
      $display("FAIL empty_done got done=%b wbv=%b uv=%b busy=%b want 1 0 0 1", done, wb_valid, uop_valid, busy);
    else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL empty_idle got busy=%b done=%b want 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_flush();
    uop_ready = 1'b1;
    go(16'h000F, 32'h3000, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (!(uop_valid === 1'b1 && uop_reg === 4'd1 && uop_addr === 32'h3004))
      $display("FAIL flush_2nd got v=%b r=%0d a=%h want v=1 r=1 a=00003004", uop_valid, uop_reg, uop_addr);
    else passed++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({busy, uop_valid, done, wb_valid} !== 4'b0)
        $display("FAIL flush_idle%0d got busy/uv/done/wbv=%b want 0000", k, {busy, uop_valid, done, wb_valid});
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    uop_ready = 1'b0;
    go(16'h00F0, 32'h4000, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (uop_valid !== 1'b1 || uop_load !== 1'b1)
      $display("FAIL areset_pre got uv=%b ld=%b want 1 1", uop_valid, uop_load);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if ({busy, uop_valid, uop_last, wb_valid, done, uop_load} !== 6'b0
                  || uop_reg !== 4'd0 || uop_addr !== 32'd0 || wb_value !== 32'd0)
      $display("FAIL areset_now got flags=%b reg=%0d addr=%h wb=%h want all 0",
               {busy, uop_valid, uop_last, wb_valid, done, uop_load}, uop_reg, uop_addr, wb_value);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    uop_ready = 1'b1;
    go(16'h0006, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (!(uop_valid === 1'b1 && uop_reg === 4'd1 && uop_addr === 32'h40 && uop_last === 1'b0))
      $display("FAIL areset_u0 got v=%b r=%0d a=%h last=%b want 1 1 00000040 0", uop_valid, uop_reg, uop_addr, uop_last);
    else passed++;
    @(negedge clk);
    checks++; if (!(uop_valid === 1'b1 && uop_reg === 4'd2 && uop_addr === 32'h44 && uop_last === 1'b1))
      $display("FAIL areset_u1 got v=%b r=%0d a=%h last=%b want 1 2 00000044 1", uop_valid, uop_reg, uop_addr, uop_last);
    else passed++;
    @(negedge clk);
    checks++; if (!(done === 1'b1 && wb_valid === 1'b1 && wb_value === 32'h48))
      $display("FAIL areset_done got done=%b wbv=%b wb=%h want 1 1 00000048", done, wb_valid, wb_value);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ia_stm();
    test_db_ldm();
    test_wrap();
    test_backpressure();
    test_empty();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
